codificador_2de5_serial: RTL and testbench
==========================================

# codificador_2de5_serial

Serial transmitter for the 2-of-5 digit code, the sending side of the 2-of-5 display path. It accepts one BCD digit at a time over a valid/ready handshake, encodes it into a 5-bit 2-of-5 codeword (E1..E5), and shifts the codeword out on a single line framed by a strobe. The receiving end deserializes E1..E5 and feeds them to the segment decoders. Digits above 9 are rejected with an error pulse and are not transmitted.

## Interface
- BIT_DIV, default 4: clock cycles per serial bit; legal range 1..255.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- dado  input  4  BCD digit to send; sampled only on an accepted transfer.
- valido  input  1  producer has a digit on dado.
- pronto  output  1  block can accept a digit; a transfer occurs on a clk edge where valido=1, pronto=1 and rst=0.
- codigo  output  5  last valid codeword latched, with codigo[4]=E1 and codigo[0]=E5.
- saida  output  1  serial line; E1 is sent first.
- quadro  output  1  high while a codeword bit is on saida.
- erro  output  1  one-cycle pulse when a digit greater than 9 is accepted.

## Operation
- Encoding uses weights 7-4-2-1-0 on E1..E5. Every codeword has exactly two ones:
  - 0=11000, 1=00011, 2=00101, 3=00110, 4=01001
  - 5=01010, 6=01100, 7=10001, 8=10010, 9=10100
- State machine:
  - OCIOSO: pronto=1, saida=0, quadro=0.
  - On a transfer with dado<=9: latch the codeword into codigo and a shift register, clear the bit index and divider, go to TRANSMITE.
  - On a transfer with dado>9: assert erro for the next cycle, leave codigo unchanged, stay in OCIOSO.
  - TRANSMITE: pronto=0, quadro=1, saida=current bit. The divider counts 0..BIT_DIV-1. At BIT_DIV-1 the index advances. After the index-4 bit (E5) completes, go to PAUSA.
  - PAUSA: pronto=0, saida=0, quadro=0 for BIT_DIV cycles, then OCIOSO.
- valido and dado are ignored outside OCIOSO. The producer must hold them until it sees the transfer.
- Reset:
  - rst=1 at any edge, including mid-frame, sets state=OCIOSO and codigo=00000, clears the shift register, divider and index, and sets saida=0, quadro=0, erro=0.
  - pronto is forced to 0 while rst=1. The frame in progress is abandoned with no partial completion.
- All outputs are registered, except pronto, which equals (state==OCIOSO && !rst).

## Timing
- Reset values: pronto=0 (during rst), saida=0, quadro=0, erro=0, codigo=00000. pronto=1 in the first cycle after rst falls.
- Transfer at edge k:
  - Cycle k+1: quadro=1, saida=E1, pronto=0, codigo updated.
  - Bit i (i=0..4) is on saida during cycles k+1+i·BIT_DIV through k+(i+1)·BIT_DIV.
  - quadro stays high for exactly 5·BIT_DIV cycles, followed by the BIT_DIV-cycle gap.
  - pronto returns to 1 at cycle k+1+6·BIT_DIV. The earliest next transfer is at that edge.
- Throughput: one digit per 6·BIT_DIV+1 cycles when valido is held continuously.
- Rejected digit at edge k: erro=1 in cycle k+1 only. pronto stays 1, so back-to-back rejects produce back-to-back erro pulses.
- BIT_DIV=1: one cycle per bit, one gap cycle, 7-cycle period.

## Test plan
- Reset then idle: hold rst 3 cycles with valido=1 -> no transfer, pronto=0 during reset; after release, pronto=1, saida=0, codigo=00000.
- Single digit, BIT_DIV=4: dado=5 accepted at edge k -> codigo=01010; saida over cycles k+1..k+20 is 0000 1111 0000 1111 0000; quadro high exactly those 20 cycles; pronto=1 at k+25.
- All digits 0..9 sent back-to-back with valido held -> each received codeword matches the table and has exactly two ones; transfers are spaced 25 cycles apart.
- Invalid digit: dado=12 accepted -> erro=1 for one cycle, quadro stays 0, codigo keeps its prior value (e.g. 10100 after a 9); a following dado=3 sends 00110.
- Reset mid-frame: dado=7 accepted, rst asserted during the third bit -> next cycle saida=0, quadro=0, codigo=00000; after release, dado=1 transmits 00011 completely.
- BIT_DIV=1 regression: dado=0 -> saida is 1,1,0,0,0 on consecutive cycles, one gap cycle, pronto=1 seven cycles after the transfer.

Source files
------------

// File: rtl/codificador_2de5_serial.sv
`default_nettype none
// ============================================================================
//  Module   : codificador_2de5_serial
//  Purpose  : Serial transmitter for the 2-of-5 digit code. Takes one BCD
//             digit over a valid/ready handshake, encodes it with weights
//             7-4-2-1-0 (E1..E5) and shifts the codeword out MSB (E1) first,
//             framed by quadro, followed by a one-bit-time idle gap.
//             Digits above 9 are rejected with a one-cycle erro pulse.
//  Ports    : clk     - rising-edge clock
//             rst     - synchronous, active-high reset
//             dado    - BCD digit, sampled on an accepted transfer
//             valido  - producer has a digit on dado
//             pronto  - block can accept a digit (combinational)
//             codigo  - last valid codeword, codigo[4]=E1 .. codigo[0]=E5
//             saida   - serial line
//             quadro  - high while a codeword bit is on saida
//             erro    - one-cycle pulse after an out-of-range digit
//  Revision : 1.0 - initial release
// ============================================================================
module codificador_2de5_serial #(
  parameter int BIT_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dado,
  input  logic       valido,
  output logic       pronto,
  output logic [4:0] codigo,
  output logic       saida,
  output logic       quadro,
  output logic       erro
);

  localparam logic [1:0] OCIOSO    = 2'd0;
  localparam logic [1:0] TRANSMITE = 2'd1;
  localparam logic [1:0] PAUSA     = 2'd2;

  localparam logic [7:0] c_DIV_MAX    = 8'(BIT_DIV - 1);
  localparam logic [2:0] c_ULTIMO_BIT = 3'd4;

  logic [1:0] r_estado;
  logic [1:0] w_prox_estado;
  logic [7:0] r_div;
  logic [2:0] r_indice;
  logic [4:0] r_desloc;
  logic [4:0] r_codigo;
  logic       r_quadro;
  logic       r_erro;
  logic [4:0] w_palavra;
  logic       w_digito_ok;
  logic       w_fim_bit;

  // 2-of-5 codeword for the digit on dado, weights 7-4-2-1-0 (0 uses 7+4)
  always_comb begin
    w_palavra = 5'b00000;
    case (dado)
      4'd0:    w_palavra = 5'b11000;
      4'd1:    w_palavra = 5'b00011;
      4'd2:    w_palavra = 5'b00101;
      4'd3:    w_palavra = 5'b00110;
      4'd4:    w_palavra = 5'b01001;
      4'd5:    w_palavra = 5'b01010;
      4'd6:    w_palavra = 5'b01100;
      4'd7:    w_palavra = 5'b10001;
      4'd8:    w_palavra = 5'b10010;
      4'd9:    w_palavra = 5'b10100;
      default: w_palavra = 5'b00000;
    endcase
  end

  assign w_digito_ok = (dado <= 4'd9);
  assign w_fim_bit   = (r_div == c_DIV_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  // Next-state logic
  always_comb begin
    w_prox_estado = r_estado;
    case (r_estado)
      OCIOSO:    if (valido && w_digito_ok) w_prox_estado = TRANSMITE;
      TRANSMITE: if (w_fim_bit && (r_indice == c_ULTIMO_BIT)) w_prox_estado = PAUSA;
      PAUSA:     if (w_fim_bit) w_prox_estado = OCIOSO;
      default:   w_prox_estado = OCIOSO;
    endcase
  end

  // Output logic: only pronto is combinational, gated by reset
  always_comb begin
    pronto = (r_estado == OCIOSO) && !rst;
  end

  // Registered datapath. saida is the MSB of the shift register; zeros are
  // shifted in, so after the fifth bit the line falls to 0 by itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= 8'd0;
      r_indice <= 3'd0;
      r_desloc <= 5'b00000;
      r_codigo <= 5'b00000;
      r_quadro <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      r_erro <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          r_div    <= 8'd0;
          r_indice <= 3'd0;
          if (valido) begin
            if (w_digito_ok) begin
              r_codigo <= w_palavra;
              r_desloc <= w_palavra;
              r_quadro <= 1'b1;
            end else begin
              r_erro <= 1'b1;
            end
          end
        end
        TRANSMITE: begin
          if (w_fim_bit) begin
            r_div    <= 8'd0;
            r_desloc <= {r_desloc[3:0], 1'b0};
            if (r_indice == c_ULTIMO_BIT) begin
              r_quadro <= 1'b0;
            end else begin
              r_indice <= r_indice + 3'd1;
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        PAUSA: begin
          if (w_fim_bit) begin
            r_div <= 8'd0;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        default: begin
          r_div    <= 8'd0;
          r_indice <= 3'd0;
        end
      endcase
    end
  end

  assign codigo = r_codigo;
  assign saida  = r_desloc[4];
  assign quadro = r_quadro;
  assign erro   = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_codificador_2de5_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_codificador_2de5_serial
//  Purpose  : Self-checking bench for codificador_2de5_serial. Two instances
//             are exercised: BIT_DIV=4 and BIT_DIV=1. Expected waveforms are
//             built from a weight-sum model of the 2-of-5 code.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_codificador_2de5_serial;

  logic       clk;
  logic       rst;
  logic [3:0] dado4, dado1;
  logic       valido4, valido1;
  logic       pronto4, pronto1;
  logic [4:0] codigo4, codigo1;
  logic       saida4, saida1;
  logic       quadro4, quadro1;
  logic       erro4, erro1;

  int checks;
  int errors;
  int cyc;

  codificador_2de5_serial #(.BIT_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .dado(dado4), .valido(valido4), .pronto(pronto4),
    .codigo(codigo4), .saida(saida4), .quadro(quadro4), .erro(erro4)
  );

  codificador_2de5_serial #(.BIT_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .dado(dado1), .valido(valido1), .pronto(pronto1),
    .codigo(codigo1), .saida(saida1), .quadro(quadro1), .erro(erro1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Reference: the codeword is the pair of positions whose weights sum to d
  // (digit 0 is represented by 7+4=11).
  function automatic logic [4:0] model_cw(input int d);
    int w[5];
    int target;
    logic [4:0] r;
    w[0] = 7; w[1] = 4; w[2] = 2; w[3] = 1; w[4] = 0;
    target = (d == 0) ? 11 : d;
    r = 5'b00000;
    for (int i = 0; i < 5; i++)
      for (int j = i + 1; j < 5; j++)
        if (w[i] + w[j] == target) begin
          r[4-i] = 1'b1;
          r[4-j] = 1'b1;
        end
    return r;
  endfunction

  function automatic logic obs_pronto(input int which);
    return (which == 1) ? pronto1 : pronto4;
  endfunction
  function automatic logic obs_saida(input int which);
    return (which == 1) ? saida1 : saida4;
  endfunction
  function automatic logic obs_quadro(input int which);
    return (which == 1) ? quadro1 : quadro4;
  endfunction
  function automatic logic obs_erro(input int which);
    return (which == 1) ? erro1 : erro4;
  endfunction
  function automatic logic [4:0] obs_codigo(input int which);
    return (which == 1) ? codigo1 : codigo4;
  endfunction

  task automatic drive(input int which, input logic v, input logic [3:0] d);
    if (which == 1) begin
      valido1 = v; dado1 = d;
    end else begin
      valido4 = v; dado4 = d;
    end
  endtask

  // Presents digit d, waits for the transfer, then records every cycle of the
  // frame (bits, gap, and the cycle where pronto returns) and compares it
  // against the model. Called at a negedge; returns at the negedge of the
  // cycle where pronto is expected back. k returns the transfer edge number.
  task automatic run_frame(input int which, input logic [3:0] d, input bit keep,
                           output int k);
    int         bd;
    int         n;
    int         waited;
    logic [4:0] cw;
    logic [63:0] got_s, got_q, got_p, got_e, exp_s, exp_q, exp_p;
    bd = (which == 1) ? 1 : 4;
    n  = 6 * bd + 1;
    cw = model_cw(int'(d));
    k  = -1;
    drive(which, 1'b1, d);
    waited = 0;
    while (!obs_pronto(which) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!obs_pronto(which)) begin
      errors++;
      $display("FAIL handshake_timeout dut%0d: pronto=%b, required 1", which, obs_pronto(which));
      drive(which, 1'b0, d);
      return;
    end
    k = cyc + 1;
    got_s = '0; got_q = '0; got_p = '0; got_e = '0;
    exp_s = '0; exp_q = '0; exp_p = '0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1 && !keep) drive(which, 1'b0, d);
      got_s[c-1] = obs_saida(which);
      got_q[c-1] = obs_quadro(which);
      got_p[c-1] = obs_pronto(which);
      got_e[c-1] = obs_erro(which);
      exp_s[c-1] = (c <= 5 * bd) ? cw[4 - (c - 1) / bd] : 1'b0;
      exp_q[c-1] = (c <= 5 * bd);
      exp_p[c-1] = (c == n);
      if (c == 1) begin
        checks++;
        if (obs_codigo(which) !== cw) begin
          errors++;
          $display("FAIL codigo_latch dut%0d d=%0d: got %b, required %b", which, d, obs_codigo(which), cw);
        end
        checks++;
        if ($countones(obs_codigo(which)) != 2) begin
          errors++;
          $display("FAIL two_ones dut%0d d=%0d: codigo %b has %0d ones, required 2", which, d,
                   obs_codigo(which), $countones(obs_codigo(which)));
        end
      end
    end
    checks++;
    if (got_s !== exp_s) begin
      errors++;
      $display("FAIL saida_wave dut%0d d=%0d: got %b, required %b", which, d, got_s[24:0], exp_s[24:0]);
    end
    checks++;
    if (got_q !== exp_q) begin
      errors++;
      $display("FAIL quadro_wave dut%0d d=%0d: got %b, required %b", which, d, got_q[24:0], exp_q[24:0]);
    end
    checks++;
    if (got_p !== exp_p) begin
      errors++;
      $display("FAIL pronto_wave dut%0d d=%0d: got %b, required %b", which, d, got_p[24:0], exp_p[24:0]);
    end
    checks++;
    if (got_e !== 64'd0) begin
      errors++;
      $display("FAIL erro_during_frame dut%0d d=%0d: got %b, required all 0", which, d, got_e[24:0]);
    end
    checks++;
    if (obs_codigo(which) !== cw) begin
      errors++;
      $display("FAIL codigo_hold dut%0d d=%0d: got %b, required %b", which, d, obs_codigo(which), cw);
    end
  endtask

  task automatic test_reset();
    logic [2:0] p_v, s_v, q_v, e_v;
    rst = 1'b1;
    drive(4, 1'b1, 4'd5);
    drive(1, 1'b1, 4'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      p_v[i] = pronto4 | pronto1;
      s_v[i] = saida4  | saida1;
      q_v[i] = quadro4 | quadro1;
      e_v[i] = erro4   | erro1;
    end
    checks++;
    if (p_v !== 3'b000) begin
      errors++;
      $display("FAIL reset_pronto: got %b, required 000", p_v);
    end
    checks++;
    if ({s_v, q_v, e_v} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: saida/quadro/erro %b %b %b, required all 0", s_v, q_v, e_v);
    end
    rst = 1'b0;
    drive(4, 1'b0, 4'd5);
    drive(1, 1'b0, 4'd3);
    #1;
    checks++;
    if (pronto4 !== 1'b1 || pronto1 !== 1'b1) begin
      errors++;
      $display("FAIL release_pronto: got %b%b, required 11", pronto4, pronto1);
    end
    checks++;
    if (codigo4 !== 5'b00000 || saida4 !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: codigo=%b saida=%b, required 00000 0", codigo4, saida4);
    end
    @(negedge clk);
    checks++;
    if (quadro4 !== 1'b0 || codigo4 !== 5'b00000 || pronto4 !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: quadro=%b codigo=%b pronto=%b, required 0 00000 1",
               quadro4, codigo4, pronto4);
    end
  endtask

  task automatic test_single_digit();
    int k;
    run_frame(4, 4'd5, 1'b0, k);
  endtask

  task automatic test_back_to_back();
    int order[10];
    int k, prev_k;
    for (int i = 0; i < 10; i++) order[i] = i;
    for (int i = 9; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    prev_k = -1;
    for (int i = 0; i < 10; i++) begin
      run_frame(4, 4'(order[i]), 1'b1, k);
      if (prev_k >= 0) begin
        checks++;
        if (k - prev_k != 25) begin
          errors++;
          $display("FAIL spacing d=%0d: got %0d cycles, required 25", order[i], k - prev_k);
        end
      end
      prev_k = k;
    end
    drive(4, 1'b0, 4'd0);
  endtask

  task automatic test_random_gaps();
    int k;
    for (int i = 0; i < 6; i++) begin
      int gap;
      gap = int'($urandom_range(5, 0));
      for (int g = 0; g < gap; g++) @(negedge clk);
      run_frame(4, 4'($urandom_range(9, 0)), 1'b0, k);
    end
  endtask

  task automatic test_invalid();
    int k;
    logic [4:0] cw9;
    cw9 = model_cw(9);
    run_frame(4, 4'd9, 1'b0, k);
    drive(4, 1'b1, 4'd12);
    @(negedge clk);
    checks++;
    if (erro4 !== 1'b1 || quadro4 !== 1'b0 || pronto4 !== 1'b1) begin
      errors++;
      $display("FAIL reject_12: erro=%b quadro=%b pronto=%b, required 1 0 1", erro4, quadro4, pronto4);
    end
    checks++;
    if (codigo4 !== cw9) begin
      errors++;
      $display("FAIL reject_keeps_codigo: got %b, required %b", codigo4, cw9);
    end
    drive(4, 1'b1, 4'($urandom_range(15, 10)));
    @(negedge clk);
    checks++;
    if (erro4 !== 1'b1 || quadro4 !== 1'b0) begin
      errors++;
      $display("FAIL reject_back_to_back: erro=%b quadro=%b, required 1 0", erro4, quadro4);
    end
    drive(4, 1'b0, 4'd0);
    @(negedge clk);
    checks++;
    if (erro4 !== 1'b0 || codigo4 !== cw9) begin
      errors++;
      $display("FAIL erro_single_pulse: erro=%b codigo=%b, required 0 %b", erro4, codigo4, cw9);
    end
    run_frame(4, 4'd3, 1'b0, k);
  endtask

  task automatic test_reset_midframe();
    int k;
    int stop_c;
    logic [4:0] cw7;
    cw7 = model_cw(7);
    drive(4, 1'b1, 4'd7);
    for (int w = 0; w < 100 && !pronto4; w++) @(negedge clk);
    checks++;
    if (!pronto4) begin
      errors++;
      $display("FAIL midframe_handshake: pronto=%b, required 1", pronto4);
      drive(4, 1'b0, 4'd7);
      return;
    end
    @(negedge clk);
    drive(4, 1'b0, 4'd7);
    // third bit (E3) occupies cycles k+9..k+12
    stop_c = int'($urandom_range(12, 9));
    for (int c = 2; c <= stop_c; c++) @(negedge clk);
    checks++;
    if (quadro4 !== 1'b1 || saida4 !== cw7[2]) begin
      errors++;
      $display("FAIL midframe_third_bit: quadro=%b saida=%b, required 1 %b", quadro4, saida4, cw7[2]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (saida4 !== 1'b0 || quadro4 !== 1'b0 || codigo4 !== 5'b00000 || pronto4 !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: saida=%b quadro=%b codigo=%b pronto=%b, required 0 0 00000 0",
               saida4, quadro4, codigo4, pronto4);
    end
    rst = 1'b0;
    run_frame(4, 4'd1, 1'b0, k);
  endtask

  task automatic test_bitdiv1();
    int k, prev_k;
    run_frame(1, 4'd0, 1'b0, k);
    prev_k = -1;
    for (int i = 0; i < 4; i++) begin
      run_frame(1, 4'($urandom_range(9, 0)), 1'b1, k);
      if (prev_k >= 0) begin
        checks++;
        if (k - prev_k != 7) begin
          errors++;
          $display("FAIL spacing_bitdiv1: got %0d cycles, required 7", k - prev_k);
        end
      end
      prev_k = k;
    end
    drive(1, 1'b0, 4'd0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    rst     = 1'b1;
    valido4 = 1'b0; dado4 = 4'd0;
    valido1 = 1'b0; dado1 = 4'd0;
    test_reset();
    test_single_digit();
    test_back_to_back();
    test_random_gaps();
    test_invalid();
    test_reset_midframe();
    test_bitdiv1();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
